// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner and its surroundings: the matrix pins,
// the decoded key outputs and the FSM state exposed for observation.
interface keypad_scanner_if;
   // Handshake: keyPressed is a level-valid for keyDecoded. A new code is
   // presented on its rising edge, and the consumer never back-pressures.
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] keyDecoded;
   logic       keyPressed;
   logic [1:0] scanState;

   modport master (
      input  rows,
      output cols,
      output keyDecoded,
      output keyPressed,
      output scanState
   );

   modport slave (
      output rows,
      input  cols,
      input  keyDecoded,
      input  keyPressed,
      input  scanState
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low column across the pad and samples the
// synchronized rows once per column dwell, then tracks the held key until it releases.
module keypad_scanner #(
   parameter int SETTLE_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              reset,
   keypad_scanner_if.master  kp
);

   localparam logic [1:0]  SCAN = 2'b00;
   localparam logic [1:0]  HELD = 2'b01;
   localparam logic [11:0] LAST = 12'(SETTLE_CYCLES - 1);

   logic [1:0]  state;
   logic [11:0] count;
   logic [1:0]  colIdx;
   logic [1:0]  rowIdx;
   logic [3:0]  rowsMeta;
   logic [3:0]  rowsSync;
   logic [3:0]  keyDecodedReg;
   logic        keyPressedReg;
   logic        samplePoint;
   logic [1:0]  lowRow;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign samplePoint = (count == LAST);

   // Lowest-numbered low row wins when several keys in one column are down.
   always_comb begin
      lowRow = 2'd3;
      if (!rowsSync[0])      lowRow = 2'd0;
      else if (!rowsSync[1]) lowRow = 2'd1;
      else if (!rowsSync[2]) lowRow = 2'd2;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rowsMeta      <= 4'b1111;
         rowsSync      <= 4'b1111;
         count         <= 12'd0;
         state         <= SCAN;
         colIdx        <= 2'd0;
         rowIdx        <= 2'd0;
         keyDecodedReg <= 4'h0;
         keyPressedReg <= 1'b0;
      end else begin
         rowsMeta <= kp.rows;
         rowsSync <= rowsMeta;
         count    <= samplePoint ? 12'd0 : count + 12'd1;

         case (state)
            SCAN: begin
               if (samplePoint) begin
                  if (rowsSync == 4'b1111) begin
                     colIdx <= colIdx + 2'd1;
                  end else begin
                     rowIdx        <= lowRow;
                     keyDecodedReg <= key_code(lowRow, colIdx);
                     keyPressedReg <= 1'b1;
                     state         <= HELD;
                  end
               end
            end
            HELD: begin
               // Only the latched row matters here; other keys cannot disturb a hold.
               if (samplePoint && rowsSync[rowIdx]) begin
                  keyPressedReg <= 1'b0;
                  colIdx        <= 2'd0;
                  state         <= SCAN;
               end
            end
            default: begin
               keyPressedReg <= 1'b0;
               colIdx        <= 2'd0;
               state         <= SCAN;
            end
         endcase
      end
   end

   assign kp.cols       = ~(4'b0001 << colIdx);
   assign kp.keyDecoded = keyDecodedReg;
   assign kp.keyPressed = keyPressedReg;
   assign kp.scanState  = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SETTLE_CYCLES = 4: a behavioural keypad drives rows
// from cols, and a monitor checks each new key code against the expected queue.
module tb_keypad_scanner;

   localparam int SETTLE = 4;

   logic clk;
   logic reset;
   keypad_scanner_if bus ();

   keypad_scanner #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (bus.master)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- keypad model ----------------
   logic [3:0] key_down [4];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         bus.rows[r] = ~|(key_down[r] & ~bus.cols);
      end
   end

   task automatic press(input int r, input int c);
      key_down[r][c] = 1'b1;
   endtask

   task automatic release_key(input int r, input int c);
      key_down[r][c] = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   logic [3:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Each rising keyPressed must carry the next expected code.
   logic prev_kp = 1'b0;
   always @(negedge clk) begin
      if (bus.keyPressed === 1'b1 && prev_kp !== 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_press", {4'h0, bus.keyDecoded}, 8'hFF);
         end else begin
            check("key_code", {4'h0, bus.keyDecoded}, {4'h0, exp_q.pop_front()});
         end
      end
      prev_kp = bus.keyPressed;
   end

   // ---------------- driver helpers ----------------
   task automatic wait_kp(input logic level, input int budget, input string name,
                          output int cycles);
      cycles = 0;
      while (bus.keyPressed !== level && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check(name, {7'd0, bus.keyPressed}, {7'd0, level});
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++) key_down[r] = 4'b0000;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int dwell;
      int bad;
      logic [3:0] exp_cols;

      release_all();
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_cols",  {4'h0, bus.cols},       8'h0E);
      check("rst_kp",    {7'd0, bus.keyPressed}, 8'h00);
      check("rst_kd",    {4'h0, bus.keyDecoded}, 8'h00);
      check("rst_state", {6'd0, bus.scanState},  8'h00);

      // Idle sweep: four samples per column, then wrap to column 0
      reset = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         exp_cols = ~(4'b0001 << ((i / 4) % 4));
         check($sformatf("sweep_%0d", i), {4'h0, bus.cols}, {4'h0, exp_cols});
         if (i < 16) @(negedge clk);
      end

      // Single press "6" starting from a column-0 boundary
      exp_q.push_back(4'h6);
      press(1, 2);
      cyc = 0;
      dwell = 0;
      while (bus.keyPressed !== 1'b1 && cyc < 40) begin
         if (bus.cols == 4'b1011) dwell++;
         @(negedge clk);
         cyc++;
      end
      check("press6_kp",    {7'd0, bus.keyPressed}, 8'h01);
      check("press6_dwell", 8'(dwell), 8'd4);
      check("press6_cols",  {4'h0, bus.cols}, 8'h0B);
      check("held_state",   {6'd0, bus.scanState}, 8'h01);
      repeat (7) @(negedge clk);
      check("press6_hold",  {4'h0, bus.cols}, 8'h0B);

      // Release
      release_key(1, 2);
      wait_kp(1'b0, 20, "release6_kp", cyc);
      check("release6_lat",  8'(cyc <= 6), 8'h01);
      check("release6_cols", {4'h0, bus.cols}, 8'h0E);
      check("release6_kd",   {4'h0, bus.keyDecoded}, 8'h06);

      // Two keys in column 0: row 1 wins, then row 3 after row 1 lets go
      exp_q.push_back(4'h4);
      press(1, 0);
      press(3, 0);
      wait_kp(1'b1, 40, "two_keys_kp", cyc);
      check("two_keys_kd", {4'h0, bus.keyDecoded}, 8'h04);
      exp_q.push_back(4'hE);
      release_key(1, 0);
      wait_kp(1'b0, 20, "two_keys_fall", cyc);
      wait_kp(1'b1, 40, "star_kp", cyc);
      check("star_cols", {4'h0, bus.cols}, 8'h0E);
      release_all();
      wait_kp(1'b0, 20, "star_release", cyc);

      // Second key ignored while "2" is held
      exp_q.push_back(4'h2);
      press(0, 1);
      wait_kp(1'b1, 40, "key2_kp", cyc);
      press(3, 3);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.keyPressed !== 1'b1 || bus.cols !== 4'b1101 || bus.keyDecoded !== 4'h2) bad++;
      end
      check("key2_ignore_D", 8'(bad), 8'd0);
      exp_q.push_back(4'hD);
      release_key(0, 1);
      wait_kp(1'b0, 20, "key2_fall", cyc);
      wait_kp(1'b1, 40, "keyD_kp", cyc);
      check("keyD_cols", {4'h0, bus.cols}, 8'h07);
      release_all();
      wait_kp(1'b0, 20, "keyD_release", cyc);

      // Asynchronous reset while "0" is held
      exp_q.push_back(4'h0);
      press(3, 1);
      wait_kp(1'b1, 40, "key0_kp", cyc);
      #1 reset = 1'b1;
      #1;
      check("async_rst_kp",   {7'd0, bus.keyPressed}, 8'h00);
      check("async_rst_cols", {4'h0, bus.cols},       8'h0E);
      check("async_rst_kd",   {4'h0, bus.keyDecoded}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back(4'h0);
      wait_kp(1'b1, 40, "key0_redetect", cyc);
      check("key0_redetect_cols", {4'h0, bus.cols}, 8'h0D);
      release_all();
      wait_kp(1'b0, 20, "key0_release", cyc);

      repeat (2) @(negedge clk);
      check("queue_empty", 8'(exp_q.size()), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case a loop above were ever unbounded.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
